// File: rtl/commit_serializer.sv
// Serializes multi-wide ROB retire bundles into a one-entry-per-cycle valid/ready stream.
// Optional canonical-nop filtering is enabled with COMMIT_SER_NOP_FILTER_EN.
module commit_serializer #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8,
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         commit_valid,
  input  logic [TAG_W-1:0]             commit_front_tag,
  input  logic [TAG_W:0]               commit_num,
  input  logic [SIZE-1:0][WIDTH-1:0]   commit_pc,
  input  logic [SIZE-1:0][6:0]         commit_opcode,
  input  logic [SIZE-1:0][4:0]         commit_rd,
  input  logic [SIZE-1:0][WIDTH-1:0]   commit_data,
  input  logic                         halt,
  output logic                         stall_commit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_pc,
  output logic [6:0]                   out_opcode,
  output logic [4:0]                   out_rd,
  output logic [WIDTH-1:0]             out_data,
  output logic [31:0]                  out_seq,
  output logic                         overflow,
  output logic                         done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TAG_W:0] SIZE_N = (TAG_W+1)'(SIZE);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, room;

  logic [WIDTH-1:0] mem_pc   [DEPTH];
  logic [6:0]       mem_op   [DEPTH];
  logic [4:0]       mem_rd   [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];

  logic [TAG_W:0]   raw_n, n_keep;
  logic [TAG_W:0]   slot_sum [SIZE];
  logic [TAG_W-1:0] slot     [SIZE];
  logic             is_nop   [SIZE];
  logic             wr_en    [SIZE];
  logic [PW-1:0]    wr_off   [SIZE];
  logic             push_req, accept, drop, pop;

  // Walk the bundle in program order; kept entries get consecutive FIFO offsets.
  always_comb begin
    raw_n  = (commit_num > SIZE_N) ? SIZE_N : commit_num;
    n_keep = '0;
    for (int i = 0; i < SIZE; i++) begin
      slot_sum[i] = {1'b0, commit_front_tag} + (TAG_W+1)'(i);
      slot[i]     = (slot_sum[i] >= SIZE_N) ? TAG_W'(slot_sum[i] - SIZE_N) : TAG_W'(slot_sum[i]);
`ifdef COMMIT_SER_NOP_FILTER_EN
      is_nop[i]   = (commit_opcode[slot[i]] == 7'h13) && (commit_rd[slot[i]] == 5'd0) &&
                    (commit_data[slot[i]] == '0);
`else
      is_nop[i]   = 1'b0;
`endif
      wr_off[i]   = PW'(n_keep);
      wr_en[i]    = (32'(i) < 32'(raw_n)) && !is_nop[i];
      if (wr_en[i]) n_keep = n_keep + (TAG_W+1)'(1);
    end
  end

  // Pre-pop occupancy decides acceptance; a same-cycle pop frees nothing.
  assign room         = CW'(DEPTH) - count;
  assign push_req     = commit_valid && (n_keep != '0) && (state != DONE);
  assign accept       = push_req && (room >= CW'(n_keep));
  assign drop         = push_req && !accept;
  assign out_valid    = (count != '0);
  assign pop          = out_valid && out_ready;
  assign stall_commit = (room < CW'(SIZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= RUN;
    end else begin
      if (accept) tail <= tail + PW'(n_keep);
      if (pop)    head <= head + PW'(1);
      count <= count + (accept ? CW'(n_keep) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      if (drop)   overflow <= 1'b1;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      RUN:     if (halt) state_next = DRAIN;
      DRAIN:   if ((count == '0) && !push_req) state_next = DONE;
      DONE:    done = 1'b1;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (accept && wr_en[i]) begin
        mem_pc[tail + wr_off[i]]   <= commit_pc[slot[i]];
        mem_op[tail + wr_off[i]]   <= commit_opcode[slot[i]];
        mem_rd[tail + wr_off[i]]   <= commit_rd[slot[i]];
        mem_data[tail + wr_off[i]] <= commit_data[slot[i]];
      end
    end
  end

  assign out_pc     = mem_pc[head];
  assign out_opcode = mem_op[head];
  assign out_rd     = mem_rd[head];
  assign out_data   = (mem_rd[head] == 5'd0) ? '0 : mem_data[head];

`ifdef COMMIT_SER_NOP_FILTER_EN
  // Each kept entry remembers its position among all retired entries, nops included.
  logic [31:0] retire_seq;
  logic [31:0] mem_seq [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_seq <= '0;
    else if (commit_valid && (state != DONE) && !drop) retire_seq <= retire_seq + 32'(raw_n);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (accept && wr_en[i]) mem_seq[tail + wr_off[i]] <= retire_seq + 32'(i);
    end
  end

  assign out_seq = mem_seq[head];
`else
  logic [31:0] pop_seq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pop_seq <= '0;
    else if (pop) pop_seq <= pop_seq + 32'd1;
  end

  assign out_seq = pop_seq;
`endif

endmodule

// File: tb/tb_commit_serializer.sv
// Directed bench for commit_serializer: wrap, overflow, same-cycle push/pop, halt, x0, clamp.
module tb_commit_serializer;

  logic            clk = 1'b0;
  logic            rst;
  logic            commit_valid;
  logic [2:0]      commit_front_tag;
  logic [3:0]      commit_num;
  logic [7:0][31:0] commit_pc;
  logic [7:0][6:0]  commit_opcode;
  logic [7:0][4:0]  commit_rd;
  logic [7:0][31:0] commit_data;
  logic            halt;
  logic            stall_commit;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [31:0]     out_data;
  logic [31:0]     out_seq;
  logic            overflow;
  logic            done;

  int vectors = 0;
  int miscompares = 0;

  commit_serializer dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_front_tag(commit_front_tag),
    .commit_num(commit_num), .commit_pc(commit_pc), .commit_opcode(commit_opcode),
    .commit_rd(commit_rd), .commit_data(commit_data), .halt(halt),
    .stall_commit(stall_commit), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_data(out_data),
    .out_seq(out_seq), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic load_rob();
    for (int s = 0; s < 8; s++) begin
      commit_pc[s]     = 32'h1000 + 32'(s * 4);
      commit_opcode[s] = 7'h33;
      commit_rd[s]     = 5'(s + 1);
      commit_data[s]   = 32'hA000 + 32'(s);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; commit_valid = 1'b0; commit_front_tag = '0; commit_num = '0;
    halt = 1'b0; out_ready = 1'b0;
    load_rob();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [2:0] tag, input logic [3:0] num);
    commit_valid = 1'b1; commit_front_tag = tag; commit_num = num;
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_num = '0;
  endtask

  task automatic drain(output int n, output logic [31:0] last);
    n = 0; last = '0; out_ready = 1'b1;
    while (out_valid && n < 64) begin
      last = out_pc;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (out_seq !== 32'd0) begin miscompares++; $display("FAIL reset_out_seq got %0d want 0", out_seq); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (stall_commit !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall_commit); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    out_ready = 1'b1;
    push(3'd6, 4'd3);
    for (int k = 0; k < 3; k++) begin
      exp_pc = 32'h1000 + 32'(((6 + k) % 8) * 4);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_seq !== 32'(k)) begin
        miscompares++;
        $display("FAIL wrap_entry%0d got v=%b pc=%h seq=%0d want v=1 pc=%h seq=%0d",
                 k, out_valid, out_pc, out_seq, exp_pc, k);
      end
      @(posedge clk); #1;
    end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_empty got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int n; logic [31:0] last;
    do_reset();
    push(3'd0, 4'd8);
    vectors++; if (stall_commit !== 1'b0) begin miscompares++; $display("FAIL ovf_stall_half got %b want 0", stall_commit); end
    push(3'd0, 4'd8);
    vectors++; if (stall_commit !== 1'b1) begin miscompares++; $display("FAIL ovf_stall_full got %b want 1", stall_commit); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b want 0", overflow); end
    push(3'd2, 4'd1);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", overflow); end
    vectors++; if (out_pc !== 32'h1000) begin miscompares++; $display("FAIL ovf_head got %h want 00001000", out_pc); end
    drain(n, last);
    vectors++; if (n !== 16 || last !== 32'h101C) begin miscompares++; $display("FAIL ovf_drain got n=%0d last=%h want n=16 last=0000101c", n, last); end
  endtask

  task automatic test_same_cycle();
    int n; logic [31:0] last;
    do_reset();
    push(3'd0, 4'd8);
    push(3'd0, 4'd7);
    vectors++; if (stall_commit !== 1'b1) begin miscompares++; $display("FAIL sc_stall got %b want 1", stall_commit); end
    out_ready = 1'b1;
    push(3'd3, 4'd1);
    out_ready = 1'b0;
    vectors++;
    if (out_pc !== 32'h1004 || out_seq !== 32'd1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL sc_head got pc=%h seq=%0d ovf=%b want pc=00001004 seq=1 ovf=0", out_pc, out_seq, overflow);
    end
    drain(n, last);
    vectors++; if (n !== 15 || last !== 32'h100C) begin miscompares++; $display("FAIL sc_drain got n=%0d last=%h want n=15 last=0000100c", n, last); end
  endtask

  task automatic test_halt();
    int n, cyc; logic [31:0] pcs [2];
    do_reset();
    out_ready = 1'b1; halt = 1'b1;
    push(3'd4, 4'd2);
    halt = 1'b0;
    n = 0; cyc = 0; pcs[0] = '0; pcs[1] = '0;
    while (!done && cyc < 20) begin
      if (out_valid) begin
        if (n < 2) pcs[n] = out_pc;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL halt_done got %b want 1", done); end
    vectors++;
    if (n !== 2 || pcs[0] !== 32'h1010 || pcs[1] !== 32'h1014) begin
      miscompares++;
      $display("FAIL halt_emitted got n=%0d pc0=%h pc1=%h want n=2 pc0=00001010 pc1=00001014", n, pcs[0], pcs[1]);
    end
    push(3'd0, 4'd8);
    push(3'd0, 4'd8);
    push(3'd0, 4'd8);
    vectors++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_ignore got v=%b ovf=%b done=%b want v=0 ovf=0 done=1", out_valid, overflow, done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_x0();
    do_reset();
    commit_rd[2] = 5'd0; commit_data[2] = 32'hDEAD;
    push(3'd2, 4'd2);
    vectors++;
    if (out_pc !== 32'h1008 || out_rd !== 5'd0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_zero got pc=%h rd=%0d data=%h want pc=00001008 rd=0 data=0", out_pc, out_rd, out_data);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    vectors++;
    if (out_rd !== 5'd4 || out_data !== 32'hA003) begin
      miscompares++;
      $display("FAIL x0_pass got rd=%0d data=%h want rd=4 data=0000a003", out_rd, out_data);
    end
  endtask

  task automatic test_clamp();
    int n; logic [31:0] last;
    do_reset();
    push(3'd0, 4'hF);
    drain(n, last);
    vectors++; if (n !== 8 || last !== 32'h101C) begin miscompares++; $display("FAIL clamp got n=%0d last=%h want n=8 last=0000101c", n, last); end
  endtask

`ifdef COMMIT_SER_NOP_FILTER_EN
  task automatic test_nop_filter();
    int n; logic [31:0] last;
    do_reset();
    commit_opcode[0] = 7'h13; commit_rd[0] = 5'd0; commit_data[0] = 32'd0;
    commit_opcode[1] = 7'h13; commit_rd[1] = 5'd5; commit_data[1] = 32'd7;
    push(3'd0, 4'd2);
    vectors++;
    if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_seq !== 32'd1) begin
      miscompares++;
      $display("FAIL nop_keep got v=%b rd=%0d seq=%0d want v=1 rd=5 seq=1", out_valid, out_rd, out_seq);
    end
    drain(n, last);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL nop_count got %0d want 1", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_overflow();
    test_same_cycle();
    test_halt();
    test_x0();
    test_clamp();
`ifdef COMMIT_SER_NOP_FILTER_EN
    test_nop_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
